// File: rtl/apb_master.sv
// apb_master: single-outstanding APB initiator.
// Takes one command from the valid/ready command stream, runs an APB SETUP
// and ACCESS transfer, and returns one response on the valid/ready response
// stream. A wait-state timeout ends the transfer if the slave holds pready
// low for too long.
//
// Ports:
//   pclk, presetn                  clock; asynchronous active-low reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_write/cmd_addr/cmd_wdata   command payload
//   rsp_valid/rsp_ready            response handshake
//   rsp_rdata/rsp_err/rsp_timeout  response payload
//   psel/penable/paddr/pwrite/pwdata  APB request (all registered)
//   prdata/pready/pslverr          APB completion from the slave
module apb_master #(
  parameter int unsigned A_WIDTH   = 32,
  parameter int unsigned D_WIDTH   = 32,
  parameter int unsigned TO_CYCLES = 256
) (
  input  logic               pclk,
  input  logic               presetn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [A_WIDTH-1:0] cmd_addr,
  input  logic [D_WIDTH-1:0] cmd_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [D_WIDTH-1:0] rsp_rdata,
  output logic               rsp_err,
  output logic               rsp_timeout,
  output logic               psel,
  output logic               penable,
  output logic [A_WIDTH-1:0] paddr,
  output logic               pwrite,
  output logic [D_WIDTH-1:0] pwdata,
  input  logic [D_WIDTH-1:0] prdata,
  input  logic               pready,
  input  logic               pslverr
);

  localparam int unsigned CW = $clog2(TO_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TO_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t        state;
  logic [CW-1:0] to_cnt;

  // cmd_ready is registered: it is 0 while in reset, rises on the first
  // clock after reset release and again on the clock of the response
  // handshake, so it is only ever 1 while the FSM sits in IDLE.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state       <= IDLE;
      to_cnt      <= '0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      paddr       <= '0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            paddr     <= cmd_addr;
            pwrite    <= cmd_write;
            pwdata    <= cmd_wdata;
            psel      <= 1'b1;
            cmd_ready <= 1'b0;
            to_cnt    <= '0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          // A ready slave on the threshold cycle still completes normally.
          if (pready) begin
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= pwrite ? '0 : prdata;
            rsp_err     <= pslverr;
            rsp_timeout <= 1'b0;
            state       <= RESP;
          end else if (to_cnt == TO_LAST) begin
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            state       <= RESP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            pwrite    <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed, self-checking bench for apb_master (TO_CYCLES=8).
// Expected responses are queued when a command is issued and compared when
// the response handshake is seen. Inputs change and outputs are sampled on
// the falling edge of pclk.
module tb_apb_master;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  logic          pclk = 1'b0;
  logic          presetn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          psel;
  logic          penable;
  logic [AW-1:0] paddr;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata = '0;
  logic          pready = 1'b1;
  logic          pslverr = 1'b0;

  always #5 pclk = ~pclk;

  apb_master #(.A_WIDTH(AW), .D_WIDTH(DW), .TO_CYCLES(TO)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
    logic          to;
  } rsp_t;

  rsp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one command (called at a falling edge); returns at the falling
  // edge of the SETUP cycle.
  task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input rsp_t exp);
    int k = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    sb.push_back(exp);
    while (!cmd_ready && k < 40) begin
      @(negedge pclk);
      k++;
    end
    chk("cmd_accept_bound", 64'(k < 40), 64'(1));
    @(posedge pclk);
    @(negedge pclk);
    cmd_valid = 1'b0;
  endtask

  task automatic cmp_rsp(input string tag);
    rsp_t e;
    chk({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 64'(1));
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    chk({tag, "_rdata"}, 64'(rsp_rdata), 64'(e.rdata));
    chk({tag, "_err"}, 64'(rsp_err), 64'(e.err));
    chk({tag, "_timeout"}, 64'(rsp_timeout), 64'(e.to));
  endtask

  // Wait (bounded) for a response, compare it, complete the handshake.
  task automatic get_rsp(input string tag);
    int k = 0;
    rsp_ready = 1'b1;
    while (!rsp_valid && k < 40) begin
      @(negedge pclk);
      k++;
    end
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(1));
    if (rsp_valid) cmp_rsp(tag);
    @(posedge pclk);
    @(negedge pclk);
    rsp_ready = 1'b0;
    chk({tag, "_rsp_drop"}, 64'(rsp_valid), 64'(0));
    chk({tag, "_idle_ready"}, 64'(cmd_ready), 64'(1));
  endtask

  initial begin
    int cnt;
    rsp_t r;

    // Reset state
    #12;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("rst_outputs", 64'({rsp_valid, rsp_err, rsp_timeout, psel, penable, pwrite}), 64'(0));
    chk("rst_paddr", 64'(paddr), 64'(0));
    @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    chk("post_rst_cmd_ready", 64'(cmd_ready), 64'(1));

    // Zero-wait write
    r = '{rdata: '0, err: 1'b0, to: 1'b0};
    send(1'b1, 32'h0, 32'h1, r);
    chk("wr_setup_psel", 64'({psel, penable}), 64'(2'b10));
    chk("wr_setup_pwrite", 64'(pwrite), 64'(1));
    chk("wr_setup_cmd_ready", 64'(cmd_ready), 64'(0));
    @(negedge pclk);
    chk("wr_access", 64'({psel, penable}), 64'(2'b11));
    chk("wr_pwdata", 64'(pwdata), 64'(32'h1));
    chk("wr_no_early_rsp", 64'(rsp_valid), 64'(0));
    @(negedge pclk);
    chk("wr_rsp_at_n3", 64'(rsp_valid), 64'(1));
    chk("wr_bus_idle", 64'({psel, penable}), 64'(0));
    get_rsp("wr0");
    chk("wr_pwrite_idle", 64'(pwrite), 64'(0));

    // Zero-wait read
    prdata = 32'hA5A5_0001;
    r = '{rdata: 32'hA5A5_0001, err: 1'b0, to: 1'b0};
    send(1'b0, 32'h40, 32'h0, r);
    chk("rd_setup_paddr", 64'(paddr), 64'(32'h40));
    chk("rd_setup_pwrite", 64'(pwrite), 64'(0));
    @(negedge pclk);
    chk("rd_access", 64'({psel, penable}), 64'(2'b11));
    chk("rd_access_paddr", 64'(paddr), 64'(32'h40));
    @(negedge pclk);
    prdata = 32'h0;
    get_rsp("rd0");

    // Wait states then slave error on the 6th ACCESS cycle
    pready = 1'b0;
    prdata = 32'h0000_1234;
    r = '{rdata: 32'h0000_1234, err: 1'b1, to: 1'b0};
    send(1'b0, 32'h300, 32'h0, r);
    cnt = 0;
    @(negedge pclk);
    while (penable && cnt < 30) begin
      cnt++;
      if (cnt == 6) begin
        pready  = 1'b1;
        pslverr = 1'b1;
      end
      @(negedge pclk);
    end
    pslverr = 1'b0;
    prdata  = 32'h0;
    chk("ws_access_cycles", 64'(cnt), 64'(6));
    get_rsp("ws");

    // Timeout with pready stuck low
    pready = 1'b0;
    prdata = 32'hDEAD_BEEF;
    r = '{rdata: '0, err: 1'b1, to: 1'b1};
    send(1'b0, 32'h200, 32'h0, r);
    cnt = 0;
    @(negedge pclk);
    while (penable && cnt < 30) begin
      cnt++;
      @(negedge pclk);
    end
    chk("to_access_cycles", 64'(cnt), 64'(TO));
    chk("to_psel_drop", 64'(psel), 64'(0));
    get_rsp("to");
    pready = 1'b1;
    r = '{rdata: '0, err: 1'b0, to: 1'b0};
    send(1'b1, 32'h204, 32'h77, r);
    get_rsp("after_to");

    // Backpressure and back-to-back command
    prdata = 32'hCAFE_0005;
    r = '{rdata: 32'hCAFE_0005, err: 1'b0, to: 1'b0};
    send(1'b0, 32'h80, 32'h0, r);
    @(negedge pclk);
    @(negedge pclk);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h84;
    cmd_wdata = 32'h55;
    r = '{rdata: '0, err: 1'b0, to: 1'b0};
    sb.push_back(r);
    for (int i = 0; i < 10; i++) begin
      prdata = 32'h1000 + 32'(i);
      chk("bp_rsp_valid", 64'(rsp_valid), 64'(1));
      chk("bp_rdata_stable", 64'(rsp_rdata), 64'(32'hCAFE_0005));
      chk("bp_cmd_ready", 64'(cmd_ready), 64'(0));
      chk("bp_psel", 64'(psel), 64'(0));
      @(negedge pclk);
    end
    cmp_rsp("bp");
    rsp_ready = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    rsp_ready = 1'b0;
    chk("b2b_rsp_drop", 64'(rsp_valid), 64'(0));
    chk("b2b_cmd_ready", 64'(cmd_ready), 64'(1));
    @(posedge pclk);
    @(negedge pclk);
    cmd_valid = 1'b0;
    chk("b2b_setup", 64'({psel, penable}), 64'(2'b10));
    chk("b2b_paddr", 64'(paddr), 64'(32'h84));
    get_rsp("b2b");

    // Reset pulse during ACCESS
    pready = 1'b0;
    r = '{rdata: '0, err: 1'b0, to: 1'b0};
    send(1'b0, 32'h100, 32'h0, r);
    void'(sb.pop_back());
    @(negedge pclk);
    chk("rstmid_in_access", 64'(penable), 64'(1));
    #2 presetn = 1'b0;
    #1;
    chk("rstmid_psel", 64'(psel), 64'(0));
    chk("rstmid_penable", 64'(penable), 64'(0));
    chk("rstmid_rsp_valid", 64'(rsp_valid), 64'(0));
    @(negedge pclk);
    presetn = 1'b1;
    pready  = 1'b1;
    @(negedge pclk);
    chk("rstmid_cmd_ready", 64'(cmd_ready), 64'(1));
    for (int i = 0; i < 5; i++) begin
      chk("rstmid_no_rsp", 64'(rsp_valid), 64'(0));
      chk("rstmid_no_psel", 64'(psel), 64'(0));
      @(negedge pclk);
    end
    chk("sb_empty", 64'(sb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
